// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronises, debounces and one-hot-checks the raw
// push buttons, then presents a held button code with jogada/invalida strobes.
// Optional auto-repeat while a button is held: define CONDICIONADOR_REPETICAO_EN.
module condicionador_botoes #(
  parameter int unsigned N_BOTOES         = 4,
  parameter int unsigned DEBOUNCE_CICLOS  = 50000,
  parameter int unsigned REPETICAO_CICLOS = 25000000,
  parameter int unsigned CNT_W            = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] botoes_out,
  output logic                jogada,
  output logic                invalida,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

  localparam int unsigned EST_W = 3;
  localparam logic [EST_W-1:0] OCIOSO        = 3'd0;
  localparam logic [EST_W-1:0] FILTRANDO     = 3'd1;
  localparam logic [EST_W-1:0] ACEITA        = 3'd2;
  localparam logic [EST_W-1:0] INVALIDA      = 3'd3;
  localparam logic [EST_W-1:0] ESPERA_SOLTAR = 3'd4;

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam int unsigned CNT_MAX =
    (DEBOUNCE_CICLOS > REPETICAO_CICLOS) ? DEBOUNCE_CICLOS : REPETICAO_CICLOS;

  // The shared counter width must cover both terminal counts.
  if ((64'(CNT_MAX) - 64'd1) > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_invalido
    $error("condicionador_botoes: CNT_W too narrow for the configured cycle counts");
  end

  logic [EST_W-1:0]    estado, estado_d;
  logic [N_BOTOES-1:0] sync1, sync;
  logic [N_BOTOES-1:0] amostra, amostra_d;
  logic [N_BOTOES-1:0] botoes_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                um_quente_c;

`ifdef CONDICIONADOR_REPETICAO_EN
  localparam logic [CNT_W-1:0] RCNT_FIM = CNT_W'(REPETICAO_CICLOS - 1);
  logic [CNT_W-1:0] rcnt, rcnt_d;
  logic             repete_ok, repete_d;
  logic             em_espera;
`endif

  assign um_quente_c = (amostra != '0) &&
                       ((amostra & (amostra - N_BOTOES'(1))) == '0);

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= botoes_in;
      sync  <= sync1;
    end
  end

  // State register plus datapath and registered Moore outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      amostra    <= '0;
      cnt        <= '0;
      botoes_out <= '0;
      jogada     <= 1'b0;
      invalida   <= 1'b0;
      ocupado    <= 1'b0;
      db_estado  <= 4'd0;
`ifdef CONDICIONADOR_REPETICAO_EN
      rcnt       <= '0;
      repete_ok  <= 1'b0;
      em_espera  <= 1'b0;
`endif
    end else begin
      estado     <= estado_d;
      amostra    <= amostra_d;
      cnt        <= cnt_d;
      botoes_out <= botoes_d;
      jogada     <= (estado_d == ACEITA);
      invalida   <= (estado_d == INVALIDA);
      ocupado    <= (estado_d != OCIOSO);
      db_estado  <= 4'(estado_d);
`ifdef CONDICIONADOR_REPETICAO_EN
      rcnt       <= rcnt_d;
      repete_ok  <= repete_d;
      em_espera  <= (estado == ESPERA_SOLTAR);
`endif
    end
  end

  // Next-state and datapath updates for press filtering and release debounce.
  always_comb begin
    estado_d  = estado;
    amostra_d = amostra;
    cnt_d     = cnt;
    botoes_d  = botoes_out;
`ifdef CONDICIONADOR_REPETICAO_EN
    rcnt_d    = rcnt;
    repete_d  = repete_ok;
`endif
    case (estado)
      OCIOSO: begin
        if (sync != '0) begin
          amostra_d = sync;
          cnt_d     = '0;
          estado_d  = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (sync == '0) begin
          estado_d = OCIOSO;
        end else if (sync != amostra) begin
          amostra_d = sync;
          cnt_d     = '0;
        end else if (cnt == CNT_FIM) begin
          if (um_quente_c) begin
            estado_d = ACEITA;
            botoes_d = amostra;
          end else begin
            estado_d = INVALIDA;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ACEITA: begin
        estado_d = ESPERA_SOLTAR;
        cnt_d    = '0;
`ifdef CONDICIONADOR_REPETICAO_EN
        rcnt_d   = '0;
        repete_d = 1'b1;
`endif
      end
      INVALIDA: begin
        estado_d = ESPERA_SOLTAR;
        cnt_d    = '0;
`ifdef CONDICIONADOR_REPETICAO_EN
        rcnt_d   = '0;
        repete_d = 1'b0;
`endif
      end
      ESPERA_SOLTAR: begin
`ifdef CONDICIONADOR_REPETICAO_EN
        // Auto-repeat: the entry cycle only clears rcnt, then it counts while held.
        if (!em_espera || !repete_ok || (sync != botoes_out)) begin
          rcnt_d = '0;
        end else if (rcnt == RCNT_FIM) begin
          estado_d = ACEITA;
          botoes_d = amostra;
        end else begin
          rcnt_d = rcnt + CNT_W'(1);
        end
`endif
        if (estado_d == ESPERA_SOLTAR) begin
          if (sync != '0) begin
            cnt_d = '0;
          end else if (cnt == CNT_FIM) begin
            estado_d = OCIOSO;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes (DEBOUNCE_CICLOS=4, REPETICAO_CICLOS=10).
// Stimulus pushes expected strobes; a monitor pops and compares on every strobe.
module tb_condicionador_botoes;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned REP = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] botoes_in = '0;
  logic [N-1:0] botoes_out;
  logic         jogada, invalida, ocupado;
  logic [3:0]   db_estado;

  typedef struct {
    logic         eh_jogada;
    logic [N-1:0] codigo;
    int           ciclo;
  } evento_t;

  evento_t esperado[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  condicionador_botoes #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(DEB), .REPETICAO_CICLOS(REP), .CNT_W(25)
  ) dut (
    .clock(clock), .reset(reset), .botoes_in(botoes_in),
    .botoes_out(botoes_out), .jogada(jogada), .invalida(invalida),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clock) begin
    if (reset && (jogada || invalida)) begin
      vectors++;
      if (esperado.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got jogada=%b invalida=%b botoes_out=%b at cycle %0d, expected no strobe",
                 jogada, invalida, botoes_out, cyc);
      end else begin
        evento_t e;
        e = esperado.pop_front();
        if (jogada !== e.eh_jogada || invalida !== !e.eh_jogada ||
            botoes_out !== e.codigo || cyc != e.ciclo) begin
          miscompares++;
          $display("FAIL strobe: got jogada=%b invalida=%b botoes_out=%b cycle=%0d, expected jogada=%b invalida=%b botoes_out=%b cycle=%0d",
                   jogada, invalida, botoes_out, cyc, e.eh_jogada, !e.eh_jogada, e.codigo, e.ciclo);
        end
      end
    end
  end

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic eh_jogada, input logic [N-1:0] codigo, input int ciclo);
    evento_t e;
    e.eh_jogada = eh_jogada;
    e.codigo    = codigo;
    e.ciclo     = ciclo;
    esperado.push_back(e);
  endtask

  task automatic espera_ocioso(input string nome);
    int n;
    n = 0;
    while (db_estado != 4'd0 && n < 100) begin
      ciclos(1);
      n++;
    end
    check(nome, 32'(db_estado), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;

    // Reset state
    ciclos(3);
    check("rst_botoes_out", 32'(botoes_out), 32'd0);
    check("rst_jogada",     32'(jogada),     32'd0);
    check("rst_invalida",   32'(invalida),   32'd0);
    check("rst_ocupado",    32'(ocupado),    32'd0);
    check("rst_db_estado",  32'(db_estado),  32'd0);
    reset = 1'b1;
    ciclos(2);

    // Test 1: reset mid-filtering
    botoes_in = 4'b0100;
    ciclos(4);
    check("t1_filtrando", 32'(db_estado), 32'd1);
    check("t1_ocupado",   32'(ocupado),   32'd1);
    reset = 1'b0;
    #1;
    check("t1_async_db_estado", 32'(db_estado), 32'd0);
    check("t1_async_ocupado",   32'(ocupado),   32'd0);
    check("t1_async_botoes",    32'(botoes_out), 32'd0);
    botoes_in = '0;
    ciclos(2);
    reset = 1'b1;
    ciclos(10);
    check("t1_idle_after", 32'(db_estado), 32'd0);
    check("t1_no_strobe_queue", 32'(esperado.size()), 32'd0);

    // Test 4: non-one-hot press gives invalida, code unchanged
    botoes_in = 4'b0011;
    e0 = cyc;
    push(1'b0, 4'b0000, e0 + 7);
    ciclos(10);
    botoes_in = '0;
    espera_ocioso("t4_idle");
    check("t4_botoes_out", 32'(botoes_out), 32'd0);
    check("t4_queue", 32'(esperado.size()), 32'd0);

    // Test 3: bounce shorter than the debounce window
    for (int i = 0; i < 3; i++) begin
      botoes_in = 4'b0001;
      ciclos(2);
      botoes_in = 4'b0000;
      ciclos(2);
    end
    espera_ocioso("t3_idle");
    check("t3_botoes_out", 32'(botoes_out), 32'd0);
    check("t3_queue", 32'(esperado.size()), 32'd0);

    // Test 2: clean press held 20 cycles, then release debounce timing
    botoes_in = 4'b0010;
    e0 = cyc;
    push(1'b1, 4'b0010, e0 + 7);
`ifdef CONDICIONADOR_REPETICAO_EN
    push(1'b1, 4'b0010, e0 + 7 + REP + 2);
`endif
    ciclos(20);
    check("t2_held_espera", 32'(db_estado), 32'd4);
    check("t2_botoes_out_held", 32'(botoes_out), 32'h2);
    botoes_in = '0;
    ciclos(5);
    check("t2_release_not_yet", 32'(db_estado), 32'd4);
    ciclos(1);
    check("t2_release_idle", 32'(db_estado), 32'd0);
    check("t2_release_ocupado", 32'(ocupado), 32'd0);
    check("t2_botoes_out", 32'(botoes_out), 32'h2);
    check("t2_queue", 32'(esperado.size()), 32'd0);

    // Test 5: second button mid-filter restarts filtering
    botoes_in = 4'b1000;
    ciclos(4);
    botoes_in = 4'b0100;
    e0 = cyc;
    push(1'b1, 4'b0100, e0 + 7);
    ciclos(12);
    botoes_in = '0;
    espera_ocioso("t5_idle");
    check("t5_botoes_out", 32'(botoes_out), 32'h4);
    check("t5_queue", 32'(esperado.size()), 32'd0);

`ifdef CONDICIONADOR_REPETICAO_EN
    // Test 6: auto-repeat every REP+2 cycles while held
    botoes_in = 4'b0001;
    e0 = cyc;
    push(1'b1, 4'b0001, e0 + 7);
    push(1'b1, 4'b0001, e0 + 19);
    push(1'b1, 4'b0001, e0 + 31);
    ciclos(40);
    botoes_in = '0;
    espera_ocioso("t6_idle");
    check("t6_botoes_out", 32'(botoes_out), 32'h1);
    check("t6_queue", 32'(esperado.size()), 32'd0);
`endif

    ciclos(3);
    check("final_queue", 32'(esperado.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
